regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter REG_COUNT, default 32, number of architectural registers (power of two, at least 2).
REQ-002 The block SHALL have parameter REG_W, default 32, register width in bits.
REQ-003 The block SHALL have parameter REG_IDX_W, default $clog2(REG_COUNT), register index width.
REQ-004 The block SHALL have parameter RD_PORTS, default 2, number of independent read ports (1..4).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port areset, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port rd_en, input, RD_PORTS bits, per-port read enable.
REQ-008 The block SHALL have port rd_reg, input, RD_PORTS*REG_IDX_W bits, packed read indices, with port p at bits [p*REG_IDX_W +: REG_IDX_W].
REQ-009 The block SHALL have port rd_data, output, RD_PORTS*REG_W bits, packed registered read data.
REQ-010 The block SHALL have port rd_busy, output, RD_PORTS bits, registered scoreboard busy flag for each read index.
REQ-011 The block SHALL have port wr_en, input, 1 bit, writeback enable.
REQ-012 The block SHALL have ports wr_reg (input, REG_IDX_W bits) and wr_data (input, REG_W bits), giving the writeback target and value.
REQ-013 The block SHALL have ports rsv_en (input, 1 bit) and rsv_reg (input, REG_IDX_W bits), which reserve (mark busy) a destination register at issue.

Function
REQ-014 On each rising edge with wr_en=1 and wr_reg!=0, the block SHALL store wr_data into registers[wr_reg]; writes to register 0 SHALL be ignored.
REQ-015 Register 0 SHALL always read as 0 and SHALL never be marked busy.
REQ-016 Read latency SHALL be one cycle: when rd_en[p]=1 at edge N, rd_data port p and rd_busy[p] SHALL reflect rd_reg port p from edge N onward.
REQ-017 When rd_en[p]=0, rd_data port p and rd_busy[p] SHALL hold their previous values.
REQ-018 A scoreboard of REG_COUNT busy bits SHALL be maintained: rsv_en=1 with rsv_reg!=0 sets busy[rsv_reg]; wr_en=1 with wr_reg!=0 clears busy[wr_reg].
REQ-019 When rsv and wr target the same nonzero register on the same edge, busy SHALL remain set and the data SHALL be written.
REQ-020 rd_busy[p] SHALL be computed from the scoreboard value after the same-edge set/clear updates are applied.
REQ-021 All read ports SHALL be fully independent; identical indices on several ports SHALL return identical data.
REQ-022 Out-of-range indices SHALL NOT occur, because REG_COUNT equals 2**REG_IDX_W.

Reset
REQ-023 While areset=1, all registers, all busy bits, rd_data and rd_busy SHALL be held at 0, independent of clk.
REQ-024 Writes, reservations and reads presented during reset SHALL be discarded, and normal operation SHALL resume on the first rising edge after areset deasserts.

Configuration
REQ-025 With macro REGFILE_BYPASS_EN defined, a read with rd_en[p]=1 whose index equals a same-edge nonzero wr_reg with wr_en=1 SHALL capture wr_data (write-to-read forwarding).
REQ-026 Without REGFILE_BYPASS_EN, that same read SHALL capture the pre-write register contents, and the new value SHALL be visible on the next enabled read.

Verification
REQ-027 The bench SHALL cover this scenario: assert areset mid-run after writing 0xDEADBEEF to r5, deassert, then read r5 on port 0 -> rd_data=0 and rd_busy=0.
REQ-028 The bench SHALL cover this scenario: write 0x1234 to r0, then read r0 on both ports -> both rd_data=0.
REQ-029 The bench SHALL cover this scenario: write 0xA5A5A5A5 to r7 and read r7 on port 1 on the same edge -> rd_data=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value without it; the next read returns 0xA5A5A5A5 in both builds.
REQ-030 The bench SHALL cover this scenario: reserve r3, then read r3 -> rd_busy=1; write r3=0x55, then read -> rd_busy=0 and rd_data=0x55.
REQ-031 The bench SHALL cover this scenario: reserve r9 and write r9=0x77 on the same edge -> a subsequent read gives rd_busy=1 and rd_data=0x77.
REQ-032 The bench SHALL cover this scenario: hold rd_en=0 while r4 changes from 0x1 to 0x2 -> rd_data holds 0x1 until rd_en is reasserted, then shows 0x2 one cycle later.

Source files
------------

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp -- multi-read-port register file with an issue scoreboard.
//
// Holds REG_COUNT registers of REG_W bits. Register 0 is hardwired to zero
// and can never be marked busy. A per-register busy bit is set when a
// destination is reserved at issue (rsv_*) and cleared on writeback (wr_*).
// If a reservation and a writeback hit the same register on the same edge,
// the reservation wins and the register stays busy, because it belongs to a
// newer instruction.
//
// Each read port registers its data and busy flag one cycle after an enabled
// read. When the port is not enabled, both outputs hold their values. The
// busy flag reflects the scoreboard after this edge's set and clear.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-edge writeback
// data to a matching read. Without it, the read returns the contents from
// before the write.
//
// Ports:
//   clk      in   clock; all state changes on the rising edge
//   areset   in   asynchronous active-high reset; clears all state
//   rd_en    in   [RD_PORTS]             per-port read enable
//   rd_reg   in   [RD_PORTS*REG_IDX_W]   packed read indices (port p at p*REG_IDX_W)
//   rd_data  out  [RD_PORTS*REG_W]       packed registered read data
//   rd_busy  out  [RD_PORTS]             registered busy flag per read port
//   wr_en    in   writeback enable
//   wr_reg   in   [REG_IDX_W]            writeback target
//   wr_data  in   [REG_W]                writeback value
//   rsv_en   in   reserve enable
//   rsv_reg  in   [REG_IDX_W]            register to mark busy
// ----------------------------------------------------------------------------
module regfile_mp #(
  parameter int REG_COUNT = 32,
  parameter int REG_W     = 32,
  parameter int REG_IDX_W = $clog2(REG_COUNT),
  parameter int RD_PORTS  = 2
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [RD_PORTS-1:0]           rd_en,
  input  logic [RD_PORTS*REG_IDX_W-1:0] rd_reg,
  output logic [RD_PORTS*REG_W-1:0]     rd_data,
  output logic [RD_PORTS-1:0]           rd_busy,
  input  logic                          wr_en,
  input  logic [REG_IDX_W-1:0]          wr_reg,
  input  logic [REG_W-1:0]              wr_data,
  input  logic                          rsv_en,
  input  logic [REG_IDX_W-1:0]          rsv_reg
);

  logic [REG_W-1:0]     regs [REG_COUNT];
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nxt;
  logic                 wr_hit;
  logic                 rsv_hit;

  logic [REG_IDX_W-1:0] rd_idx [RD_PORTS];
  logic [REG_W-1:0]     rd_val [RD_PORTS];
  logic [RD_PORTS-1:0]  rd_bsy_nxt;

  logic [REG_W-1:0]     rd_data_p1 [RD_PORTS];
  logic [RD_PORTS-1:0]  rd_busy_p1;

  // Register 0 is excluded here, so it is never written and never marked busy.
  assign wr_hit  = wr_en  && (wr_reg  != '0);
  assign rsv_hit = rsv_en && (rsv_reg != '0);

  // Apply the clear first and then the set, so a same-edge reserve wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit)  busy_nxt[wr_reg]  = 1'b0;
    if (rsv_hit) busy_nxt[rsv_reg] = 1'b1;
  end

  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_idx[p] = rd_reg[p*REG_IDX_W +: REG_IDX_W];
      rd_val[p] = regs[rd_idx[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (wr_reg == rd_idx[p])) rd_val[p] = wr_data;
`endif
      if (rd_idx[p] == '0) rd_val[p] = '0;
      rd_bsy_nxt[p] = busy_nxt[rd_idx[p]];
    end
  end

  // ---- stage p0: architectural state (registers + scoreboard) ----
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_hit) regs[wr_reg] <= wr_data;
      busy <= busy_nxt;
    end
  end

  // ---- stage p1: registered read ports (hold while not enabled) ----
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int p = 0; p < RD_PORTS; p++) rd_data_p1[p] <= '0;
      rd_busy_p1 <= '0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        if (rd_en[p]) begin
          rd_data_p1[p] <= rd_val[p];
          rd_busy_p1[p] <= rd_bsy_nxt[p];
        end
      end
    end
  end

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd_out
    assign rd_data[g*REG_W +: REG_W] = rd_data_p1[g];
  end

  assign rd_busy = rd_busy_p1;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int REG_COUNT = 32;
  localparam int REG_W     = 32;
  localparam int REG_IDX_W = 5;
  localparam int RD_PORTS  = 2;
  localparam int RRW       = RD_PORTS*REG_IDX_W;

  logic                 clk = 1'b0;
  logic                 areset;
  logic [RD_PORTS-1:0]  rd_en;
  logic [RRW-1:0]       rd_reg;
  logic [RD_PORTS*REG_W-1:0] rd_data;
  logic [RD_PORTS-1:0]  rd_busy;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_reg;
  logic [REG_W-1:0]     wr_data;
  logic                 rsv_en;
  logic [REG_IDX_W-1:0] rsv_reg;

  regfile_mp #(
    .REG_COUNT(REG_COUNT), .REG_W(REG_W), .REG_IDX_W(REG_IDX_W), .RD_PORTS(RD_PORTS)
  ) dut (
    .clk(clk), .areset(areset), .rd_en(rd_en), .rd_reg(rd_reg), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain arrays for the architectural registers and busy bits.
  logic [REG_W-1:0] m_regs [REG_COUNT];
  bit               m_busy [REG_COUNT];
  logic [REG_W-1:0] e_data [RD_PORTS];
  bit               e_busy [RD_PORTS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REG_W-1:0] port_data(input int p);
    return rd_data[p*REG_W +: REG_W];
  endfunction

  task automatic idle();
    rd_en = '0; rd_reg = '0; wr_en = 1'b0; wr_reg = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_reg = '0;
  endtask

  task automatic set_rd(input int p, input int r);
    rd_en[p] = 1'b1;
    rd_reg[p*REG_IDX_W +: REG_IDX_W] = REG_IDX_W'(r);
  endtask

  task automatic set_wr(input int r, input logic [REG_W-1:0] d);
    wr_en = 1'b1; wr_reg = REG_IDX_W'(r); wr_data = d;
  endtask

  task automatic set_rsv(input int r);
    rsv_en = 1'b1; rsv_reg = REG_IDX_W'(r);
  endtask

  task automatic model_reset();
    for (int i = 0; i < REG_COUNT; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    for (int p = 0; p < RD_PORTS; p++) begin e_data[p] = '0; e_busy[p] = 1'b0; end
  endtask

  // One rising edge of the specified behaviour, evaluated on the current inputs.
  task automatic model_edge();
    bit wr_hit, rsv_hit;
    bit nb [REG_COUNT];
    int wi, si, ri;
    wi = int'(wr_reg);
    si = int'(rsv_reg);
    wr_hit  = wr_en  && (wi != 0);
    rsv_hit = rsv_en && (si != 0);
    for (int i = 0; i < REG_COUNT; i++)
      nb[i] = (rsv_hit && si == i) ? 1'b1 : (wr_hit && wi == i) ? 1'b0 : m_busy[i];
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rd_en[p]) begin
        ri = int'(rd_reg[p*REG_IDX_W +: REG_IDX_W]);
        e_data[p] = m_regs[ri];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && wi == ri) e_data[p] = wr_data;
`endif
        e_busy[p] = nb[ri];
      end
    end
    for (int i = 0; i < REG_COUNT; i++) m_busy[i] = nb[i];
    if (wr_hit) m_regs[wi] = wr_data;
  endtask

  task automatic compare_all(input string tag);
    for (int p = 0; p < RD_PORTS; p++) begin
      chk($sformatf("%s_data%0d", tag, p), 64'(port_data(p)), 64'(e_data[p]));
      chk($sformatf("%s_busy%0d", tag, p), 64'(rd_busy[p]), 64'(e_busy[p]));
    end
  endtask

  // Inputs are set about 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
    idle();
  endtask

  // Mid-cycle reset: outputs must clear without an edge, and traffic during reset is lost.
  task automatic do_reset();
    idle();
    areset = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    set_wr(5, 32'hCAFE_F00D);
    set_rsv(6);
    rd_en = '1;
    rd_reg = RRW'({5'd5, 5'd6});
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    idle();
    areset = 1'b0;
  endtask

  initial begin
    idle();
    areset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all("por");
    areset = 1'b0;

    // Write, then reset in mid-run, then read r5 on port 0.
    set_wr(5, 32'hDEAD_BEEF); set_rsv(5); tick("s27_wr");
    do_reset();
    set_rd(0, 5); tick("s27_rd");
    chk("s27_data", 64'(port_data(0)), 64'h0);
    chk("s27_busy", 64'(rd_busy[0]), 64'h0);

    // Writes to r0 are ignored.
    set_wr(0, 32'h1234); set_rsv(0); tick("s28_wr");
    set_rd(0, 0); set_rd(1, 0); tick("s28_rd");
    chk("s28_data0", 64'(port_data(0)), 64'h0);
    chk("s28_data1", 64'(port_data(1)), 64'h0);
    chk("s28_busy0", 64'(rd_busy[0]), 64'h0);

    // Same-edge write and read of r7.
    set_wr(7, 32'h11); tick("s29_pre");
    set_wr(7, 32'hA5A5_A5A5); set_rd(1, 7); tick("s29_same");
`ifdef REGFILE_BYPASS_EN
    chk("s29_same_data", 64'(port_data(1)), 64'hA5A5_A5A5);
`else
    chk("s29_same_data", 64'(port_data(1)), 64'h11);
`endif
    set_rd(1, 7); tick("s29_next");
    chk("s29_next_data", 64'(port_data(1)), 64'hA5A5_A5A5);

    // Reserve, then write back r3.
    set_rsv(3); tick("s30_rsv");
    set_rd(0, 3); tick("s30_rd1");
    chk("s30_busy_set", 64'(rd_busy[0]), 64'h1);
    set_wr(3, 32'h55); tick("s30_wr");
    set_rd(0, 3); tick("s30_rd2");
    chk("s30_busy_clr", 64'(rd_busy[0]), 64'h0);
    chk("s30_data", 64'(port_data(0)), 64'h55);

    // Reserve and write r9 on the same edge: the reservation wins.
    set_rsv(9); set_wr(9, 32'h77); tick("s31_both");
    set_rd(0, 9); set_rd(1, 9); tick("s31_rd");
    chk("s31_busy", 64'(rd_busy[0]), 64'h1);
    chk("s31_data", 64'(port_data(0)), 64'h77);
    chk("s31_data_p1", 64'(port_data(1)), 64'h77);

    // Read port holds while it is not enabled.
    set_wr(4, 32'h1); tick("s32_w1");
    set_rd(0, 4); tick("s32_rd1");
    chk("s32_first", 64'(port_data(0)), 64'h1);
    set_wr(4, 32'h2); tick("s32_w2");
    chk("s32_hold_a", 64'(port_data(0)), 64'h1);
    tick("s32_idle");
    chk("s32_hold_b", 64'(port_data(0)), 64'h1);
    set_rd(0, 4); tick("s32_rd2");
    chk("s32_new", 64'(port_data(0)), 64'h2);

    // Randomized traffic; small index range makes collisions frequent.
    for (int c = 0; c < 600; c++) begin
      if (c % 200 == 150) do_reset();
      rd_en   = RD_PORTS'($urandom);
      for (int p = 0; p < RD_PORTS; p++)
        set_rd(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, REG_COUNT-1) : $urandom_range(0, 7));
      rd_en   = rd_en & RD_PORTS'($urandom);
      wr_en   = 1'($urandom_range(0, 1));
      wr_reg  = REG_IDX_W'($urandom_range(0, 7));
      wr_data = $urandom;
      rsv_en  = 1'($urandom_range(0, 1));
      rsv_reg = REG_IDX_W'($urandom_range(0, 7));
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
